// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//
// ID/EX operand stage that sits directly in front of the ALU operation units.
// It registers one decoded instruction, resolves RAW hazards by forwarding from
// the EX/MEM (fwd1) and MEM/WB (fwd2) result buses, and presents SrcA/SrcB to
// the ALU behind a valid/ready handshake. While EX stalls, the held operands
// are re-resolved every cycle against the live forwarding buses, so a producer
// that retires during the stall is still picked up.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   flush                       kill held and incoming instruction
//   in_valid / in_ready         upstream handshake
//   in_rs1, in_rs2, in_rd       register indices (x0 reads as zero)
//   in_rs1_data, in_rs2_data    register file read values
//   in_imm, in_alu_src          immediate and SrcB select (1: imm)
//   in_alu_op, in_reg_write     control fields passed through
//   fwd1_we/rd/data             EX/MEM result (higher priority)
//   fwd2_we/rd/data             MEM/WB result
//   out_valid / out_ready       downstream handshake
//   SrcA, SrcB, out_store_data  resolved ALU operands and store data
//   out_rd, out_alu_op,
//   out_reg_write               control passthrough
//   fwd_count                   saturating count of forwarded operands

module ex_operand_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned OPCODE_LENGTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  in_alu_op,
    input  logic                      in_reg_write,

    input  logic                      fwd1_we,
    input  logic [REG_ADDR_WIDTH-1:0] fwd1_rd,
    input  logic [DATA_WIDTH-1:0]     fwd1_data,
    input  logic                      fwd2_we,
    input  logic [REG_ADDR_WIDTH-1:0] fwd2_rd,
    input  logic [DATA_WIDTH-1:0]     fwd2_data,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [OPCODE_LENGTH-1:0]  out_alu_op,
    output logic                      out_reg_write,
    output logic [7:0]                fwd_count
);

    // ------------------------------------------------------------------------
    // Operand resolution helpers
    // ------------------------------------------------------------------------

    // True when a forwarding bus supplies register rs. x0 never matches, which
    // also covers a producer that nominally writes x0.
    function automatic logic fwd_match(
        input logic                      we,
        input logic [REG_ADDR_WIDTH-1:0] rd,
        input logic [REG_ADDR_WIDTH-1:0] rs
    );
        return we && (rd == rs) && (rs != '0);
    endfunction

    // Priority: x0 -> zero, then EX/MEM, then MEM/WB, then the fallback value.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     fallback,
        input logic                      f1_we,
        input logic [REG_ADDR_WIDTH-1:0] f1_rd,
        input logic [DATA_WIDTH-1:0]     f1_data,
        input logic                      f2_we,
        input logic [REG_ADDR_WIDTH-1:0] f2_rd,
        input logic [DATA_WIDTH-1:0]     f2_data
    );
        logic [DATA_WIDTH-1:0] val;
        if (rs == '0) begin
            val = '0;
        end else if (fwd_match(f1_we, f1_rd, rs)) begin
            val = f1_data;
        end else if (fwd_match(f2_we, f2_rd, rs)) begin
            val = f2_data;
        end else begin
            val = fallback;
        end
        return val;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------

    logic                      valid_q,      valid_d;
    logic [DATA_WIDTH-1:0]     src_a_q,      src_a_d;
    logic [DATA_WIDTH-1:0]     src_b_q,      src_b_d;
    logic [DATA_WIDTH-1:0]     store_data_q, store_data_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;
    logic [OPCODE_LENGTH-1:0]  alu_op_q,     alu_op_d;
    logic                      reg_write_q,  reg_write_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,        rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,        rs2_d;
    logic                      alu_src_q,    alu_src_d;
    logic [DATA_WIDTH-1:0]     imm_q,        imm_d;
    logic [7:0]                fwd_count_q,  fwd_count_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------

    logic accept;
    logic stall;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stall    = valid_q && !out_ready && !flush;

    // ------------------------------------------------------------------------
    // Resolution of the incoming instruction
    // ------------------------------------------------------------------------

    logic [DATA_WIDTH-1:0] in_rs1_res;
    logic [DATA_WIDTH-1:0] in_rs2_res;
    logic [1:0]            in_fwd_hits;

    always_comb begin
        in_rs1_res = resolve(in_rs1, in_rs1_data, fwd1_we, fwd1_rd, fwd1_data,
                             fwd2_we, fwd2_rd, fwd2_data);
        in_rs2_res = resolve(in_rs2, in_rs2_data, fwd1_we, fwd1_rd, fwd1_data,
                             fwd2_we, fwd2_rd, fwd2_data);
        // rs2 counts even when the immediate replaces it on SrcB.
        in_fwd_hits = {1'b0, fwd_match(fwd1_we, fwd1_rd, in_rs1) ||
                             fwd_match(fwd2_we, fwd2_rd, in_rs1)}
                    + {1'b0, fwd_match(fwd1_we, fwd1_rd, in_rs2) ||
                             fwd_match(fwd2_we, fwd2_rd, in_rs2)};
    end

    // ------------------------------------------------------------------------
    // Re-resolution of the held instruction during a stall
    // ------------------------------------------------------------------------

    // The currently registered operand values act as the fallback, so a value
    // captured from a forward in an earlier cycle survives once that producer
    // has left the forwarding buses.
    logic [DATA_WIDTH-1:0] held_rs1_res;
    logic [DATA_WIDTH-1:0] held_rs2_res;

    always_comb begin
        held_rs1_res = resolve(rs1_q, src_a_q, fwd1_we, fwd1_rd, fwd1_data,
                               fwd2_we, fwd2_rd, fwd2_data);
        held_rs2_res = resolve(rs2_q, store_data_q, fwd1_we, fwd1_rd, fwd1_data,
                               fwd2_we, fwd2_rd, fwd2_data);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------

    always_comb begin
        valid_d      = valid_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        alu_op_d     = alu_op_q;
        reg_write_d  = reg_write_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        alu_src_d    = alu_src_q;
        imm_d        = imm_q;
        fwd_count_d  = fwd_count_q;

        // Flush wins over accept and over stall.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            src_a_d      = in_rs1_res;
            src_b_d      = in_alu_src ? in_imm : in_rs2_res;
            store_data_d = in_rs2_res;
            rd_d         = in_rd;
            alu_op_d     = in_alu_op;
            reg_write_d  = in_reg_write;
            rs1_d        = in_rs1;
            rs2_d        = in_rs2;
            alu_src_d    = in_alu_src;
            imm_d        = in_imm;

            if ({1'b0, fwd_count_q} + {7'd0, in_fwd_hits} > 9'd255) begin
                fwd_count_d = 8'd255;
            end else begin
                fwd_count_d = fwd_count_q + {6'd0, in_fwd_hits};
            end
        end else if (stall) begin
            // Control fields hold; only operand values refresh.
            src_a_d      = held_rs1_res;
            src_b_d      = alu_src_q ? imm_q : held_rs2_res;
            store_data_d = held_rs2_res;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            alu_op_q     <= '0;
            reg_write_q  <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            alu_src_q    <= 1'b0;
            imm_q        <= '0;
            fwd_count_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            alu_op_q     <= alu_op_d;
            reg_write_q  <= reg_write_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            alu_src_q    <= alu_src_d;
            imm_q        <= imm_d;
            fwd_count_q  <= fwd_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    assign out_valid      = valid_q;
    assign SrcA           = src_a_q;
    assign SrcB           = src_b_q;
    assign out_store_data = store_data_q;
    assign out_rd         = rd_q;
    assign out_alu_op     = alu_op_q;
    assign out_reg_write  = reg_write_q;
    assign fwd_count      = fwd_count_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
//
// Directed testbench for ex_operand_stage: reset state, plain issue, forward
// priority, x0 handling, stall refresh, flush and fwd_count saturation.

module tb_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_alu_src;
    logic [3:0]  in_alu_op;
    logic        in_reg_write;
    logic        fwd1_we, fwd2_we;
    logic [4:0]  fwd1_rd, fwd2_rd;
    logic [31:0] fwd1_data, fwd2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA, SrcB, out_store_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_alu_op;
    logic        out_reg_write;
    logic [7:0]  fwd_count;

    int n_checks = 0;
    int n_pass   = 0;

    ex_operand_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .OPCODE_LENGTH  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_rd          (in_rd),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_alu_src     (in_alu_src),
        .in_alu_op      (in_alu_op),
        .in_reg_write   (in_reg_write),
        .fwd1_we        (fwd1_we),
        .fwd1_rd        (fwd1_rd),
        .fwd1_data      (fwd1_data),
        .fwd2_we        (fwd2_we),
        .fwd2_rd        (fwd2_rd),
        .fwd2_data      (fwd2_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .SrcA           (SrcA),
        .SrcB           (SrcB),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_alu_op     (out_alu_op),
        .out_reg_write  (out_reg_write),
        .fwd_count      (fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic alu_src, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [3:0] op);
        in_valid     = 1'b1;
        in_rs1       = rs1;
        in_rs1_data  = d1;
        in_rs2       = rs2;
        in_rs2_data  = d2;
        in_alu_src   = alu_src;
        in_imm       = imm;
        in_rd        = rd;
        in_alu_op    = op;
        in_reg_write = 1'b1;
    endtask

    task automatic set_fwd(input logic we1, input logic [4:0] rd1, input logic [31:0] d1,
                           input logic we2, input logic [4:0] rd2, input logic [31:0] d2);
        fwd1_we   = we1;
        fwd1_rd   = rd1;
        fwd1_data = d1;
        fwd2_we   = we2;
        fwd2_rd   = rd2;
        fwd2_data = d2;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        issue(5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 4'h0);
        in_valid = 1'b0;
        in_reg_write = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_fwd_count", {24'd0, fwd_count}, 32'd0);
        check("rst_srca", SrcA, 32'h0);

        // Plain issue, no forwarding: XOR x3, x4
        issue(5'd3, 32'h0000_000A, 5'd4, 32'h0000_0005, 1'b0, 32'h0, 5'd5, 4'h4);
        tick();
        check("plain_valid", {31'd0, out_valid}, 32'd1);
        check("plain_srca", SrcA, 32'h0000_000A);
        check("plain_srcb", SrcB, 32'h0000_0005);
        check("plain_store", out_store_data, 32'h0000_0005);
        check("plain_rd", {27'd0, out_rd}, 32'd5);
        check("plain_op", {28'd0, out_alu_op}, 32'h4);
        check("plain_count", {24'd0, fwd_count}, 32'd0);

        // fwd1 beats fwd2 for the same register; immediate on SrcB
        issue(5'd7, 32'h0000_0099, 5'd8, 32'h0000_0033, 1'b1, 32'h0000_0100, 5'd6, 4'h1);
        set_fwd(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        tick();
        check("prio_srca", SrcA, 32'h0000_0011);
        check("prio_srcb", SrcB, 32'h0000_0100);
        check("prio_store", out_store_data, 32'h0000_0033);
        check("prio_count", {24'd0, fwd_count}, 32'd1);

        // Both operands forwarded, from different buses
        issue(5'd6, 32'h1, 5'd9, 32'h2, 1'b0, 32'h0, 5'd7, 4'h2);
        set_fwd(1'b1, 5'd9, 32'h77, 1'b1, 5'd6, 32'h66);
        tick();
        check("both_srca", SrcA, 32'h0000_0066);
        check("both_srcb", SrcB, 32'h0000_0077);
        check("both_count", {24'd0, fwd_count}, 32'd3);

        // x0 never matches a forward
        issue(5'd0, 32'h5, 5'd2, 32'h12, 1'b0, 32'h0, 5'd1, 4'h3);
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
        tick();
        check("x0_srca", SrcA, 32'h0);
        check("x0_srcb", SrcB, 32'h12);
        check("x0_count", {24'd0, fwd_count}, 32'd3);

        // Stall: held rs2=9 picks up a late MEM/WB forward
        issue(5'd1, 32'h40, 5'd9, 32'h1, 1'b0, 32'h0, 5'd4, 4'h5);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check("hold_srcb0", SrcB, 32'h1);
        out_ready = 1'b0;
        issue(5'd2, 32'hDEAD, 5'd3, 32'hBEEF, 1'b0, 32'h0, 5'd8, 4'h6);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("stall_srcb", SrcB, 32'h55);
        check("stall_store", out_store_data, 32'h55);
        check("stall_srca", SrcA, 32'h40);
        check("stall_rd", {27'd0, out_rd}, 32'd4);
        check("stall_count", {24'd0, fwd_count}, 32'd3);
        set_fwd(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
        tick();
        check("stall_prio", SrcB, 32'hAA);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check("stall_keep", SrcB, 32'hAA);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush with an incoming and a held instruction
        issue(5'd3, 32'h3C, 5'd0, 32'h0, 1'b0, 32'h0, 5'd2, 4'h1);
        tick();
        check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        flush = 1'b1;
        issue(5'd3, 32'h1, 5'd3, 32'h2, 1'b0, 32'h0, 5'd2, 4'h1);
        set_fwd(1'b1, 5'd3, 32'h99, 1'b0, 5'd0, 32'h0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_count", {24'd0, fwd_count}, 32'd3);
        check("flush_srca", SrcA, 32'h3C);

        // Saturation: 130 back-to-back double forwards from 3 -> 255
        out_ready = 1'b1;
        issue(5'd10, 32'h0, 5'd11, 32'h0, 1'b0, 32'h0, 5'd1, 4'h0);
        set_fwd(1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2);
        for (int i = 0; i < 130; i++) tick();
        check("sat_count", {24'd0, fwd_count}, 32'd255);

        // Async reset in the middle of a stall
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        issue(5'd3, 32'h7, 5'd4, 32'h8, 1'b0, 32'h0, 5'd1, 4'h2);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_srca", SrcA, 32'h0);
        check("mid_rst_srcb", SrcB, 32'h0);
        check("mid_rst_count", {24'd0, fwd_count}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        issue(5'd3, 32'h0000_000A, 5'd4, 32'h0000_0005, 1'b0, 32'h0, 5'd5, 4'h4);
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_srca", SrcA, 32'h0000_000A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
